perm_engine: RTL and testbench

Parametrised, pipelined bit-permutation engine with a run-time loadable table and a forward/inverse mode per transaction.
Successor to the fixed 32-bit DES P-box in the encryption datapath.
Data moves over valid/ready handshakes and feeds the round-function pipeline.
After reset the table holds the DES P mapping, so the block is a drop-in P-box with no configuration.

---
 rtl/perm_pkg.sv | 50 +++++
 rtl/perm_stage.sv | 27 ++
 rtl/perm_engine.sv | 115 +++++++++++
 tb/tb_perm_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perm_pkg.sv
// Shared types, the DES P reset table and the bit-permutation helpers used by perm_engine.
package perm_pkg;

  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_IDX_W = 6;
  localparam int unsigned DES_W     = 32;
  localparam int unsigned DES_IDX_W = 5;

  typedef logic [MAX_W-1:0]                word_t;
  typedef logic [MAX_W-1:0][MAX_IDX_W-1:0] tbl_t;

  // Listed tbl[31] down to tbl[0]
  localparam logic [DES_W-1:0][DES_IDX_W-1:0] DES_P_TABLE = {
    5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
    5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
    5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
    5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
  };

  // out[j] = data[tbl[j]]; bits at and above the active width are don't-care
  function automatic word_t perm_fwd(word_t data, tbl_t tbl);
    word_t r;
    r = '0;
    for (int unsigned j = 0; j < MAX_W; j++) r[j] = data[tbl[j]];
    return r;
  endfunction

  // out[tbl[i]] = data[i]; ascending i so the highest source wins a collision
  function automatic word_t perm_inv(word_t data, tbl_t tbl, int unsigned width);
    word_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) r[tbl[i]] = data[i];
    end
    return r;
  endfunction

  function automatic tbl_t default_table(int unsigned width);
    tbl_t t;
    t = '0;
    for (int unsigned j = 0; j < MAX_W; j++) begin
      if (j < width) begin
        if (width == DES_W) t[j] = MAX_IDX_W'(DES_P_TABLE[j[4:0]]);
        else                t[j] = MAX_IDX_W'(j);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/perm_stage.sv
// Elastic valid/ready register slice; loads when empty or when its contents leave this cycle.
module perm_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready_c = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_ready_c) out_valid <= in_valid;
      if (in_valid && in_ready_c) out_data <= in_data;
    end
  end

endmodule

// File: rtl/perm_engine.sv
// Pipelined bit-permutation engine with a run-time loadable table and per-word forward/inverse mode.
module perm_engine
  import perm_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned IDX_W  = $clog2(WIDTH),
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [IDX_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_err
);

  localparam tbl_t INIT_TBL = default_table(WIDTH);

  logic [WIDTH-1:0][IDX_W-1:0] tbl;

  logic             s1_ready_c;
  logic             s1_load_c;
  logic             pipe_empty_c;
  logic             src_inv_c;
  logic [WIDTH-1:0] src_data_c;
  logic [WIDTH-1:0] perm_res_c;
  logic             cfg_bad_c;
  logic             cfg_wr_c;
  tbl_t             ext_tbl_c;
  word_t            ext_data_c;

  // A pending table write blocks new input so the pipeline drains before the table changes
  assign in_ready  = !cfg_we && s1_ready_c;
  assign s1_load_c = in_valid && !cfg_we;
  assign cfg_ready = cfg_we && pipe_empty_c;
  assign cfg_bad_c = (32'(cfg_data) >= WIDTH) || (32'(cfg_addr) >= WIDTH);
  assign cfg_wr_c  = cfg_ready && !cfg_bad_c;

  always_comb begin
    ext_tbl_c = '0;
    for (int unsigned j = 0; j < WIDTH; j++) ext_tbl_c[j] = MAX_IDX_W'(tbl[j]);
  end

  assign ext_data_c = MAX_W'(src_data_c);
  assign perm_res_c = src_inv_c ? WIDTH'(perm_inv(ext_data_c, ext_tbl_c, WIDTH))
                                : WIDTH'(perm_fwd(ext_data_c, ext_tbl_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < WIDTH; j++) tbl[j] <= IDX_W'(INIT_TBL[j]);
      cfg_err <= 1'b0;
    end else begin
      if (cfg_wr_c) tbl[cfg_addr] <= cfg_data;
      cfg_err <= cfg_ready && cfg_bad_c;
    end
  end

  if (STAGES == 2) begin : g_two
    logic           s1_valid;
    logic           s2_ready_c;
    logic [WIDTH:0] s1_q;

    perm_stage #(.W(WIDTH + 1)) u_s1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (s1_load_c),
      .in_ready_c (s1_ready_c),
      .in_data    ({in_inv, in_data}),
      .out_valid  (s1_valid),
      .out_ready  (s2_ready_c),
      .out_data   (s1_q)
    );

    assign src_inv_c  = s1_q[WIDTH];
    assign src_data_c = s1_q[WIDTH-1:0];

    perm_stage #(.W(WIDTH)) u_s2 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (s1_valid),
      .in_ready_c (s2_ready_c),
      .in_data    (perm_res_c),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
    );

    assign pipe_empty_c = !s1_valid && !out_valid;
  end else begin : g_one
    assign src_inv_c  = in_inv;
    assign src_data_c = in_data;

    perm_stage #(.W(WIDTH)) u_s1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (s1_load_c),
      .in_ready_c (s1_ready_c),
      .in_data    (perm_res_c),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
    );

    assign pipe_empty_c = !out_valid;
  end

endmodule

// File: tb/tb_perm_engine.sv
// Directed scoreboard bench: 32-bit DES P engine, plus 8-bit single-stage and 6-bit config-check instances.
module tb_perm_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit, 2-stage instance
  logic        in_valid, in_ready, in_inv, out_valid, cfg_we, cfg_ready, cfg_err;
  logic        out_ready = 1'b1;
  logic [31:0] in_data, out_data;
  logic [4:0]  cfg_addr, cfg_data;

  // 8-bit, 1-stage instance
  logic       a_valid, a_ready, a_inv, a_out_valid, a_cfg_we, a_cfg_ready, a_cfg_err;
  logic       a_out_ready;
  logic [7:0] a_data, a_out_data;
  logic [2:0] a_cfg_addr, a_cfg_data;

  // 6-bit, 1-stage instance (out-of-range config is representable here)
  logic       b_valid, b_ready, b_inv, b_out_valid, b_cfg_we, b_cfg_ready, b_cfg_err;
  logic       b_out_ready;
  logic [5:0] b_data, b_out_data;
  logic [2:0] b_cfg_addr, b_cfg_data;

  perm_engine #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err)
  );

  perm_engine #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_inv(a_inv), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr), .cfg_data(a_cfg_data), .cfg_ready(a_cfg_ready),
    .cfg_err(a_cfg_err)
  );

  perm_engine #(.WIDTH(6), .STAGES(1)) dut6 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_inv(b_inv), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data), .cfg_ready(b_cfg_ready),
    .cfg_err(b_cfg_err)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  int tbl_m[32];
  int des_list[32] = '{15, 6, 19, 20, 28, 11, 27, 16, 0, 14, 22, 25, 4, 17, 30, 9,
                       1, 7, 23, 13, 31, 26, 2, 8, 18, 12, 29, 5, 21, 10, 3, 24};
  bit          bp_en = 1'b0;
  logic [1:0]  bp_cnt = 2'd0;
  logic [3:0]  bp_pat = 4'b1001;
  int          stall_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model table: des_list is tbl[31] first
  task automatic reset_model();
    for (int j = 0; j < 32; j++) tbl_m[j] = des_list[31 - j];
  endtask

  function automatic logic [31:0] m_fwd(input logic [31:0] x);
    logic [31:0] r;
    for (int j = 0; j < 32; j++) r[j] = x[tbl_m[j]];
    return r;
  endfunction

  function automatic logic [31:0] m_inv(input logic [31:0] x);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r[tbl_m[i]] = x[i];
    return r;
  endfunction

  // Output-side backpressure pattern 1,0,0,1 when enabled
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      out_ready = bp_pat[bp_cnt];
      bp_cnt++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Scoreboard consumer and stall-stability monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        check("q_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) check("out_data", out_data, q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send(input logic [31:0] d, input logic inv, input logic [31:0] exp);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(exp);
        acc = 1'b1;
      end else begin
        stall_cnt++;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic cfg6(input logic [2:0] a, input logic [2:0] d, input logic [31:0] err_exp,
                      input string tag);
    b_cfg_we = 1'b1; b_cfg_addr = a; b_cfg_data = d;
    @(negedge clk);
    check({tag, "_ready"}, 32'(b_cfg_ready), 32'd1);
    @(posedge clk); #1;
    b_cfg_we = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, 32'(b_cfg_err), err_exp);
    @(posedge clk); #1;
  endtask

  task automatic run6(input logic [5:0] d, input logic inv, input logic [5:0] exp, input string tag);
    b_valid = 1'b1; b_data = d; b_inv = inv;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 32'(b_out_valid), 32'd1);
    check({tag, "_data"}, 32'(b_out_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x;
    bit got;
    int n;
    rst = 1'b1;
    in_valid = 0; in_data = '0; in_inv = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    a_valid = 0; a_data = '0; a_inv = 0; a_out_ready = 1; a_cfg_we = 0; a_cfg_addr = '0; a_cfg_data = '0;
    b_valid = 0; b_data = '0; b_inv = 0; b_out_ready = 1; b_cfg_we = 0; b_cfg_addr = '0; b_cfg_data = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_b_cfg_err", 32'(b_cfg_err), 32'd0);
    @(posedge clk); #1;

    // WIDTH=8, STAGES=1: identity table, latency 1
    a_valid = 1'b1; a_data = 8'hA5;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    check("w8_valid", 32'(a_out_valid), 32'd1);
    check("w8_data", 32'(a_out_data), 32'h0000_00A5);
    @(posedge clk); #1;
    @(negedge clk);
    check("w8_single", 32'(a_out_valid), 32'd0);
    @(posedge clk); #1;

    // WIDTH=6: out-of-range writes rejected with a one-cycle error pulse, good write applied
    cfg6(3'd2, 3'd6, 32'd1, "bad_data");
    @(negedge clk);
    check("err_pulse_end", 32'(b_cfg_err), 32'd0);
    @(posedge clk); #1;
    cfg6(3'd7, 3'd1, 32'd1, "bad_addr");
    cfg6(3'd0, 3'd5, 32'd0, "good_cfg");
    run6(6'h24, 1'b0, 6'h25, "w6_fwd");
    run6(6'h01, 1'b1, 6'h00, "w6_inv_collide");

    // Test 1: forward DES P with fixed latency of two cycles
    send(32'h0000_0001, 1'b0, 32'h0080_0000);
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat2_valid", 32'(out_valid), 32'd1);
    check("lat2_data", out_data, 32'h0080_0000);
    @(posedge clk); #1;
    send(32'h8000_0000, 1'b0, 32'h0000_0800);
    drain("drain_t1");

    // Test 2: inverse, then random forward/inverse round trips
    send(32'h0080_0000, 1'b1, 32'h0000_0001);
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      send(x, 1'b0, m_fwd(x));
      send(m_fwd(x), 1'b1, x);
    end
    drain("drain_t2");
    check("model_roundtrip", m_inv(m_fwd(32'h1234_5678)), 32'h1234_5678);

    // Test 3: backpressure burst
    stall_cnt = 0;
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = 32'h0101_0101 * (i + 1);
      send(x, i[0], i[0] ? m_inv(x) : m_fwd(x));
    end
    check("bp_in_ready_drop", 32'(stall_cnt > 0), 32'd1);
    drain("drain_t3");
    bp_en = 1'b0;
    @(posedge clk); #1;

    // Test 4: table write while two words are in flight
    send(32'h0000_0001, 1'b0, 32'h0080_0000);
    send(32'h8000_0000, 1'b0, 32'h0000_0800);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 5'd0;
    in_valid = 1'b1; in_data = 32'h0000_0001; in_inv = 1'b0;
    @(negedge clk);
    check("cfg_blocks_in", 32'(in_ready), 32'd0);
    check("cfg_wait_drain", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (cfg_ready) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
      n++;
    end
    check("cfg_ready_seen", 32'(got), 32'd1);
    check("cfg_wins_over_in", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    in_valid = 1'b0;
    tbl_m[0] = 0;
    send(32'h0000_0001, 1'b0, 32'h0080_0001);
    drain("drain_t4");

    // Test 6: reset mid-burst drops in-flight words and restores DES P
    send(32'h0000_0001, 1'b0, 32'h0080_0001);
    send(32'h0000_0002, 1'b0, m_fwd(32'h0000_0002));
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    @(negedge clk);
    check("mid_rst_dropped", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(32'h0000_0001, 1'b0, 32'h0080_0000);
    send(32'h8000_0000, 1'b0, 32'h0000_0800);
    drain("drain_t6");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
